// File: rtl/core_sequencer_pkg.sv
// rtl/core_sequencer_pkg.sv - shared state encoding and limits for the ForthCPU phase sequencer
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_STARTUP = 3'd0,
        SEQ_FETCH   = 3'd1,
        SEQ_DECODE  = 3'd2,
        SEQ_EXECUTE = 3'd3,
        SEQ_EXEC2   = 3'd4,
        SEQ_COMMIT  = 3'd5,
        SEQ_STOPPED = 3'd6
    } seq_state_t;

    localparam int SEQ_CNT_W          = 4;
    localparam int STARTUP_CYCLES_MIN = 1;
    localparam int STARTUP_CYCLES_MAX = 15;
    localparam int WAIT_STATES_MIN    = 0;
    localparam int WAIT_STATES_MAX    = 7;

endpackage

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - FETCH/DECODE/EXECUTE/COMMIT phase sequencer with wait states and debug run/step/halt
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int STARTUP_CYCLES = 4,
    parameter int WAIT_STATES    = 0
) (
    input  logic CLK,
    input  logic RESET,
    input  logic RUN,
    input  logic STEP,
    input  logic HALT,
    input  logic EXTEND,
    input  logic MEM_ACCESS,
    output logic FETCH,
    output logic DECODE,
    output logic EXECUTE,
    output logic COMMIT,
    output logic EXEC2,
    output logic PHASE_WAIT,
    output logic STOPPED,
    output logic INSTR_DONE
);

    localparam logic [SEQ_CNT_W-1:0] STARTUP_LOAD = SEQ_CNT_W'(STARTUP_CYCLES);
    localparam logic [SEQ_CNT_W-1:0] WAIT_LOAD    = SEQ_CNT_W'(WAIT_STATES);

    seq_state_t           state_q, state_d;
    logic [SEQ_CNT_W-1:0] cnt_q, cnt_d;
    logic                 halt_q, halt_d;
    logic                 ext_q, ext_d;
    logic                 mem_q, mem_d;
    logic                 step_mode_q, step_mode_d;
    logic                 run_q, run_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        halt_d      = halt_q;
        ext_d       = ext_q;
        mem_d       = mem_q;
        step_mode_d = step_mode_q;
        run_d       = (state_q == SEQ_STARTUP) ? run_q : RUN;

        unique case (state_q)
            SEQ_STARTUP: begin
                if (cnt_q == '0) begin
                    state_d = RUN ? SEQ_FETCH : SEQ_STOPPED;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SEQ_FETCH: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             state_d = SEQ_DECODE;
            end
            SEQ_DECODE: begin
                halt_d  = HALT;
                ext_d   = EXTEND;
                mem_d   = MEM_ACCESS;
                state_d = SEQ_EXECUTE;
                // Register-only execute gets a zero count so it never stretches.
                cnt_d   = MEM_ACCESS ? WAIT_LOAD : '0;
            end
            SEQ_EXECUTE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ext_q ? SEQ_EXEC2 : SEQ_COMMIT;
                    cnt_d   = ext_q ? WAIT_LOAD : '0;
                end
            end
            SEQ_EXEC2: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             state_d = SEQ_COMMIT;
            end
            SEQ_COMMIT: begin
                if (halt_q || !RUN || step_mode_q) begin
                    state_d = SEQ_STOPPED;
                end else begin
                    state_d = SEQ_FETCH;
                    cnt_d   = WAIT_LOAD;
                end
            end
            SEQ_STOPPED: begin
                // A run edge takes priority so a simultaneous step still free-runs.
                if (RUN && !run_q) begin
                    state_d     = SEQ_FETCH;
                    cnt_d       = WAIT_LOAD;
                    step_mode_d = 1'b0;
                    halt_d      = 1'b0;
                end else if (STEP) begin
                    state_d     = SEQ_FETCH;
                    cnt_d       = WAIT_LOAD;
                    step_mode_d = 1'b1;
                    halt_d      = 1'b0;
                end
            end
            default: begin
                state_d = SEQ_STARTUP;
                cnt_d   = STARTUP_LOAD;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= SEQ_STARTUP;
            cnt_q       <= STARTUP_LOAD;
            halt_q      <= 1'b0;
            ext_q       <= 1'b0;
            mem_q       <= 1'b0;
            step_mode_q <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            halt_q      <= halt_d;
            ext_q       <= ext_d;
            mem_q       <= mem_d;
            step_mode_q <= step_mode_d;
            run_q       <= run_d;
        end
    end

    assign FETCH      = (state_q == SEQ_FETCH);
    assign DECODE     = (state_q == SEQ_DECODE);
    assign EXECUTE    = (state_q == SEQ_EXECUTE) || (state_q == SEQ_EXEC2);
    assign EXEC2      = (state_q == SEQ_EXEC2);
    assign COMMIT     = (state_q == SEQ_COMMIT);
    assign INSTR_DONE = (state_q == SEQ_COMMIT);
    assign STOPPED    = (state_q == SEQ_STOPPED);
    assign PHASE_WAIT = (FETCH || EXECUTE) && (cnt_q != '0);

    a_startup_range: assert property (@(posedge CLK)
        (STARTUP_CYCLES >= STARTUP_CYCLES_MIN) && (STARTUP_CYCLES <= STARTUP_CYCLES_MAX));
    a_wait_range: assert property (@(posedge CLK)
        (WAIT_STATES >= WAIT_STATES_MIN) && (WAIT_STATES <= WAIT_STATES_MAX));

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Phase sequencer for the ForthCPU core. It generates the one-hot FETCH/DECODE/EXECUTE/COMMIT phase strobes and STOPPED for the datapath, bus and register file. It inserts memory wait states and a second execute cycle for immediate-word instructions, and implements halt, run and single-step control for the debug port.

## Interface
- STARTUP_CYCLES, 4: idle cycles after reset release before the first phase (1..15).
- WAIT_STATES, 0: extra cycles held on each memory-access phase (0..7).

- CLK  in  1  system clock, all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- RUN  in  1  debug run level; tie to 1 for free-running.
- STEP  in  1  debug single-step pulse, one cycle wide.
- HALT  in  1  decoder: current instruction is HALT; sampled in DECODE.
- EXTEND  in  1  decoder: instruction carries an immediate word (e.g. LD HERE); sampled in DECODE.
- MEM_ACCESS  in  1  decoder: EXECUTE performs a load/store; sampled in DECODE.
- FETCH, DECODE, EXECUTE, COMMIT  out  1 each  phase strobes, one-hot or all zero.
- EXEC2  out  1  second execute cycle (immediate fetch); EXECUTE is also high.
- PHASE_WAIT  out  1  current phase is in a wait-state cycle; bus strobes must hold.
- STOPPED  out  1  sequencer idle in the stopped state.
- INSTR_DONE  out  1  single-cycle pulse in the final COMMIT cycle.

## Operation
- States: STARTUP, FETCH, DECODE, EXECUTE, EXEC2, COMMIT, STOPPED.
- Outputs are a Moore decode of the registered state and counter. No input reaches an output combinationally.
- **Reset**
  - State STARTUP, counter = STARTUP_CYCLES.
  - Every output is 0, including STOPPED.
  - Internal latches (halt, ext, mem, step_mode, run_q) are 0.
- **STARTUP**
  - The counter decrements each cycle.
  - At 0, the next state is FETCH if RUN=1, otherwise STOPPED.
- **FETCH**
  - Lasts 1+WAIT_STATES cycles.
  - PHASE_WAIT is high on all but the last cycle.
  - Next state is DECODE.
- **DECODE**
  - Lasts 1 cycle.
  - Latches HALT, EXTEND and MEM_ACCESS.
  - Next state is EXECUTE.
- **EXECUTE**
  - Lasts 1 cycle, or 1+WAIT_STATES if mem is latched.
  - Next state is EXEC2 if ext is latched, otherwise COMMIT.
- **EXEC2**
  - Lasts 1+WAIT_STATES cycles; EXECUTE and EXEC2 are both high.
  - Next state is COMMIT.
- **COMMIT**
  - Lasts 1 cycle; INSTR_DONE=1.
  - Next state is STOPPED if halt is latched, RUN=0, or step_mode=1. Otherwise FETCH.
- **STOPPED**
  - STOPPED=1.
  - A RUN rising edge (RUN=1 while run_q=0) goes to FETCH with step_mode=0 and halt cleared.
  - Else a STEP pulse goes to FETCH with step_mode=1 and halt cleared.
- **Boundary conditions**
  - RUN edge and STEP in the same cycle: RUN wins and the sequencer free-runs.
  - STEP outside STOPPED is ignored and not queued.
  - RUN falling mid-instruction: the instruction completes through COMMIT, then the sequencer enters STOPPED.
  - HALT with RUN=1: the sequencer stops after COMMIT. A RUN 0→1 edge or a STEP is needed to resume.
  - RESET asserted mid-instruction: immediately returns to STARTUP with every output 0. The partial instruction is abandoned.
  - WAIT_STATES=0: every phase is 1 cycle and PHASE_WAIT stays 0.

## Timing
- With WAIT_STATES=0 and no extension, an instruction takes 4 cycles (F, D, E, C).
- The general cycle count is 4 + WAIT_STATES×(1 + mem + ext) + ext.
- The first FETCH is asserted STARTUP_CYCLES+1 rising edges after RESET deasserts, when RUN=1.
- COMMIT to the next FETCH is back-to-back, with no bubble.
- run_q is registered every cycle, outside STARTUP.
- The wait counter is 4 bits. It is reloaded with WAIT_STATES on entry to FETCH, EXECUTE (when mem=1) and EXEC2.

## Structure
- Shared core package:
  - seq_state_t enum (SEQ_STARTUP … SEQ_STOPPED).
  - SEQ_CNT_W = 4.
  - Legal-range limits for STARTUP_CYCLES and WAIT_STATES.
- Single module with no sub-modules; the counter and edge detect are inline.
- Parameter-range assertions are simulation-only.

## Test plan
- **Reset release:** RESET high 2 cycles, then low with RUN=1 and STARTUP_CYCLES=4. Outputs stay 0 for 4 cycles, FETCH rises on cycle 5, and the pattern F, D, E, C repeats every 4 cycles.
- **Load/store wait states:** WAIT_STATES=2, MEM_ACCESS=1 in DECODE. FETCH lasts 3 cycles and EXECUTE lasts 3 cycles, with PHASE_WAIT high on the first 2 of each. INSTR_DONE arrives 8 cycles after FETCH rises.
- **Immediate word:** WAIT_STATES=0, EXTEND=1. Sequence is F, D, E, E+EXEC2, C: 5 cycles with one INSTR_DONE.
- **Halt:** HALT=1 in DECODE with RUN=1. STOPPED=1 the cycle after COMMIT and stays high for 20 cycles. A RUN 1→0→1 restarts at FETCH.
- **Single-step:** in STOPPED with RUN=0, a STEP pulse gives exactly one F, D, E, C, then STOPPED. A STEP during EXECUTE gives no second instruction. STEP and a RUN edge in the same cycle free-run.
- **Reset mid-instruction:** RESET asserted during EXEC2 with WAIT_STATES=3. All outputs drop to 0 asynchronously, and after release the STARTUP count restarts from 4.
